// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
//   Shared definitions for the RV32M divide/remainder sequencer (div_ctrl).
//   - funct3 codes for DIV/DIVU/REM/REMU
//   - 2-bit FSM state encoding
//   - operand width and iteration counter (DivCntBus) width
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  localparam int DIV_XLEN  = 32;
  // Width of the iteration counter bus: log2(DIV_XLEN).
  localparam int DIV_CNT_W = 5;

  // funct3 codes of the M-extension divide group.
  // Bit 0 set = unsigned, bit 1 set = remainder.
  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    DivIdle  = 2'b00,
    DivStart = 2'b01,
    DivCalc  = 2'b10,
    DivEnd   = 2'b11
  } div_state_e;

  typedef logic [DIV_CNT_W-1:0] div_cnt_t;

endpackage

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//   Multi-cycle divide/remainder unit for RV32M DIV, DIVU, REM, REMU.
//   Operands are accepted from execute, the pipeline is held through ctrl
//   while a restoring shift-subtract runs one quotient bit per cycle, and the
//   result is returned with a one-cycle write-back strobe.
//
// Handshake:
//   start_i is a request that is only looked at in IDLE; it is accepted on a
//   rising clk edge where the FSM is IDLE, start_i=1 and flush_i=0. There is
//   no back-pressure and no queueing: requests while busy are dropped. The
//   result is presented for exactly one cycle with ready_o=1 (no ready input
//   from the consumer); the next request can be accepted in the following
//   cycle.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   start_i        divide request (sampled only in IDLE)
//   op_i[2:0]      funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend_i     rs1 value
//   divisor_i      rs2 value
//   rd_addr_i      destination register
//   flush_i        abort, highest priority in every state
//   busy_o         FSM not IDLE
//   hold_flag_o    stall request to ctrl
//   ready_o        result strobe (one cycle)
//   result_o       quotient or remainder (holds last value)
//   wen_o          register write enable (ready_o and rd_addr_o != 0)
//   rd_addr_o      destination register for write-back
//   dbg_state_o    current FSM state, for observation only
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, |dividend| < |divisor| (divisor nonzero)
//                     finishes from START without iterating.
// -----------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic            wen_o,
  output logic [4:0]      rd_addr_o,
  output div_state_e      dbg_state_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q,    state_d;
  logic [2:0]       op_q,       op_d;
  logic [XLEN-1:0]  dividend_q, dividend_d;
  logic [XLEN-1:0]  divisor_q,  divisor_d;
  logic [4:0]       rd_addr_q,  rd_addr_d;
  logic [XLEN-1:0]  dq_q,       dq_d;        // dividend bits shifting out, quotient bits shifting in
  logic [XLEN-1:0]  div_mag_q,  div_mag_d;   // divisor magnitude
  logic [XLEN-1:0]  rem_q,      rem_d;       // partial remainder
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             neg_quo_q,  neg_quo_d;
  logic             neg_rem_q,  neg_rem_d;
  logic [XLEN-1:0]  result_q,   result_d;

  logic            accept;
  logic            signed_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, overflow, early_out;
  logic [XLEN:0]   rem_shift, rem_diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next, quo_next;
  logic            last_iter;

  assign accept = (state_q == DivIdle) && start_i && !flush_i;

  // Every divide funct3 has bit 2 set; folding it in keeps any other code on
  // the unsigned path rather than giving it meaning.
  assign signed_op = op_q[2] && !op_q[0];
  assign a_neg     = signed_op && dividend_q[XLEN-1];
  assign b_neg     = signed_op && divisor_q[XLEN-1];
  assign a_mag     = a_neg ? -dividend_q : dividend_q;
  assign b_mag     = b_neg ? -divisor_q  : divisor_q;
  assign div_zero  = (divisor_q == '0);
  assign overflow  = signed_op && (dividend_q == INT_MIN) && (divisor_q == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = !div_zero && (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not borrow (top bit clear).
  assign rem_shift = {rem_q, dq_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, div_mag_q};
  assign q_bit     = !rem_diff[XLEN];
  assign rem_next  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_next  = {dq_q[XLEN-2:0], q_bit};
  assign last_iter = (cnt_q == CNT_W'(XLEN-1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= DivIdle;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rd_addr_q  <= '0;
      dq_q       <= '0;
      div_mag_q  <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rd_addr_q  <= rd_addr_d;
      dq_q       <= dq_d;
      div_mag_q  <= div_mag_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = DivIdle;
    end else begin
      case (state_q)
        DivIdle:  if (start_i) state_d = DivStart;
        DivStart: state_d = (div_zero || overflow || early_out) ? DivEnd : DivCalc;
        DivCalc:  if (last_iter) state_d = DivEnd;
        DivEnd:   state_d = DivIdle;
        default:  state_d = DivIdle;
      endcase
    end
  end

  // Datapath next values. A flush freezes everything, so an operation that
  // is aborted on its final edge never reaches result_o.
  always_comb begin
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rd_addr_d  = rd_addr_q;
    dq_d       = dq_q;
    div_mag_d  = div_mag_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    if (!flush_i) begin
      case (state_q)
        DivIdle: begin
          if (accept) begin
            op_d       = op_i;
            dividend_d = dividend_i;
            divisor_d  = divisor_i;
            rd_addr_d  = rd_addr_i;
          end
        end
        DivStart: begin
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_zero) begin
            result_d = op_q[1] ? dividend_q : '1;
          end else if (overflow) begin
            result_d = op_q[1] ? '0 : INT_MIN;
          end else if (early_out) begin
            result_d = op_q[1] ? dividend_q : '0;
          end else begin
            dq_d      = a_mag;
            div_mag_d = b_mag;
            rem_d     = '0;
            cnt_d     = '0;
          end
        end
        DivCalc: begin
          dq_d  = quo_next;
          rem_d = rem_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            if (op_q[1]) result_d = neg_rem_q ? -rem_next : rem_next;
            else         result_d = neg_quo_q ? -quo_next : quo_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. ready_o/wen_o are gated by flush_i so an abort in END never
  // writes back.
  always_comb begin
    busy_o      = (state_q != DivIdle);
    hold_flag_o = accept || (state_q == DivStart) || (state_q == DivCalc);
    ready_o     = (state_q == DivEnd) && !flush_i;
    wen_o       = ready_o && (rd_addr_q != 5'd0);
    result_o    = result_q;
    rd_addr_o   = rd_addr_q;
    dbg_state_o = state_q;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle divide/remainder unit and sequencer for the RV32M DIV, DIVU, REM and REMU instructions.
- Instantiated in the execute stage. Decode passes these instructions with register write disabled; this block completes them.
- Accepts operands from ex, holds the pipeline through ctrl while iterating, then returns the result with a one-cycle write-back strobe.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start_i  in  1  divide request from ex. Sampled only in IDLE.
- op_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- dividend_i  in  XLEN  rs1 value, already forwarded.
- divisor_i  in  XLEN  rs2 value, already forwarded.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  abort from ctrl (taken jump/branch).
- busy_o  out  1  FSM not in IDLE.
- hold_flag_o  out  1  stall request to ctrl.
- ready_o  out  1  result valid, one-cycle pulse.
- result_o  out  XLEN  quotient or remainder.
- wen_o  out  1  register write enable to write-back.
- rd_addr_o  out  5  destination for write-back.

Behaviour:
- Reset: state IDLE. All outputs and internal registers 0. Reset mid-operation discards the division with no ready_o.
- FSM states: IDLE, START, CALC, END.
- IDLE → START when start_i=1 and flush_i=0.
  - At that edge, latch op_i, dividend_i, divisor_i, rd_addr_i.
  - Operand changes after acceptance are ignored.
- START (1 cycle): resolve special cases, else load the magnitudes.
  - Signed ops (DIV/REM) use |dividend| and |divisor|.
  - Store the result sign: quotient is negative when the operand signs differ; remainder takes the dividend's sign.
  - Divisor == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend. Go to END.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0. Go to END.
  - Otherwise go to CALC with the counter at 0.
- CALC: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Uses an XLEN+1-bit partial remainder.
  - After 32 iterations (counter == 31 at the edge) go to END.
  - At that edge, apply the sign correction (two's-complement negate) and select quotient or remainder by op_i[1].
- END (1 cycle): ready_o=1, result_o valid, rd_addr_o valid. wen_o=1 if rd_addr_o != 0. Next edge → IDLE.
- Outside END: ready_o=0 and wen_o=0. result_o holds its last value.
- Latency, counted as cycles after the acceptance edge:
  - Normal case: ready_o in cycle 34.
  - Special cases: ready_o in cycle 2.
  - A back-to-back start_i is accepted in the cycle after END.
- hold_flag_o = (IDLE & start_i & ~flush_i) | START | CALC. It is low in END, so the pipeline resumes as the result writes back.
- busy_o = state != IDLE.
- start_i while busy is ignored, with no queueing.
- flush_i has priority in every state: next state IDLE, no ready_o/wen_o, latched data discarded. flush_i together with start_i in IDLE means no acceptance.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in START, if the unsigned magnitude compare gives |dividend| < |divisor| (divisor nonzero), skip CALC. Quotient = 0; remainder = the original signed dividend. Go to END, so ready_o appears in cycle 2.
- Undefined: these cases take the full 32-iteration path with identical results.

Decomposition:
- Shared defines file holds:
  - the existing INST_DIV, INST_DIVU, INST_REM and INST_REMU funct3 codes;
  - a new 2-bit state encoding: DivIdle 00, DivStart 01, DivCalc 10, DivEnd 11;
  - the DivCntBus width.
- No sub-module is needed. The FSM and datapath share registers tightly and stay in one module.

Test Plan:
- DIVU 100/7 → result 14, ready_o in cycle 34, hold_flag_o high in cycles 0–33; REMU 100/7 → 2.
- DIV 0xFFFFFFF9 (-7)/2 → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1); REM 7/0xFFFFFFFE (-2) → 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, ready_o in cycle 2; DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Accept DIVU 1000/10 with rd=5, assert flush_i in CALC cycle 10 → busy_o low next cycle, no ready_o/wen_o; a new start the following cycle completes normally.
- Keep start_i high with new operands during busy → ignored; first result returned; second accepted only after END.
- rd=0 → ready_o pulses with wen_o=0. With DIV_EARLY_OUT_EN, DIVU 3/9 → 0 in cycle 2; REM 0xFFFFFFFD/9 → 0xFFFFFFFD.
